// File: rtl/dot8_seq_ctrl_if.sv
// Operand-memory, dot8 and job-control signals of one dot8 sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the memory and the dot8 pipeline accept one chunk per cycle.
//
// Ports (master = sequencer side):
//   start/base_addr/num_chunks -> job request;   busy/done/result <- job status
//   rd_en/rd_addr <- memory read;                rd_data0/rd_data1 -> chunk pair
//   dot_vec0/dot_vec1/dot_ivalid <- dot8 input;  dot_result/dot_ovalid -> dot8 output
interface dot8_seq_ctrl_if #(
   parameter int IWIDTH = 8,
   parameter int OWIDTH = 32,
   parameter int AWIDTH = 10,
   parameter int CWIDTH = 8
);
   logic                  start;
   logic [AWIDTH-1:0]     base_addr;
   logic [CWIDTH-1:0]     num_chunks;
   logic                  busy;
   logic                  done;
   logic [OWIDTH-1:0]     result;
   logic                  rd_en;
   logic [AWIDTH-1:0]     rd_addr;
   logic [8*IWIDTH-1:0]   rd_data0;
   logic [8*IWIDTH-1:0]   rd_data1;
   logic [8*IWIDTH-1:0]   dot_vec0;
   logic [8*IWIDTH-1:0]   dot_vec1;
   logic                  dot_ivalid;
   logic [OWIDTH-1:0]     dot_result;
   logic                  dot_ovalid;

   modport master (
      input  start, base_addr, num_chunks, rd_data0, rd_data1, dot_result, dot_ovalid,
      output busy, done, result, rd_en, rd_addr, dot_vec0, dot_vec1, dot_ivalid
   );

   modport slave (
      output start, base_addr, num_chunks, rd_data0, rd_data1, dot_result, dot_ovalid,
      input  busy, done, result, rd_en, rd_addr, dot_vec0, dot_vec1, dot_ivalid
   );
endinterface

// File: rtl/dot8_seq_ctrl.sv
// Sequences a long dot product of 8*num_chunks elements through one dot8 pipeline.
// Latency: start accepted in cycle 0 -> done in cycle N+7 (cycle 1 when N=0).
// Backpressure: none; one read per cycle, start ignored while busy or in the done cycle.
//
// Ports: clk, rst (synchronous, active-high); bus (dot8_seq_ctrl_if.master) carries
// the job request/status, the operand-memory read port and the dot8 in/out signals.
// Build option: define DOT8_SEQ_SAT_EN to saturate the accumulator instead of wrapping.
module dot8_seq_ctrl #(
   parameter int IWIDTH  = 8,
   parameter int OWIDTH  = 32,
   parameter int AWIDTH  = 10,
   parameter int CWIDTH  = 8,
   parameter int DOT_LAT = 5
) (
   input  logic              clk,
   input  logic              rst,
   dot8_seq_ctrl_if.master   bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                   state, state_nxt;
   logic [AWIDTH-1:0]        base_q;
   logic [CWIDTH-1:0]        num_q;
   logic [CWIDTH-1:0]        issue_cnt;
   logic [CWIDTH-1:0]        rcv_cnt;
   logic signed [OWIDTH-1:0] acc, acc_sum, acc_nxt, result_q;
   logic                     ivalid_q;
   logic [DOT_LAT-1:0]       lat_q;
   logic                     rd_en, clr, load_res, acc_en;

`ifdef DOT8_SEQ_SAT_EN
   localparam logic signed [OWIDTH-1:0] ACC_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
   localparam logic signed [OWIDTH-1:0] ACC_MIN = {1'b1, {(OWIDTH-1){1'b0}}};
   logic [OWIDTH:0] sum_wide;

   // One guard bit; the top two bits disagree exactly when the sum left the range.
   always_comb begin
      sum_wide = {acc[OWIDTH-1], acc} + {bus.dot_result[OWIDTH-1], bus.dot_result};
      acc_sum  = sum_wide[OWIDTH-1:0];
      if (sum_wide[OWIDTH] != sum_wide[OWIDTH-1])
         acc_sum = sum_wide[OWIDTH] ? ACC_MIN : ACC_MAX;
   end
`else
   always_comb begin
      acc_sum = acc + $signed(bus.dot_result);
   end
`endif

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      clr       = 1'b0;
      load_res  = 1'b0;
      acc_en    = bus.dot_ovalid && (state == ISSUE || state == DRAIN);
      case (state)
         IDLE: begin
            if (bus.start) begin
               clr = 1'b1;
               if (bus.num_chunks != '0) begin
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = DONE;
                  load_res  = 1'b1;
               end
            end
         end
         ISSUE: begin
            rd_en = 1'b1;
            if (issue_cnt == num_q - 1'b1)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            // Count the arriving result too, so done lands the cycle after the last one.
            if (rcv_cnt + CWIDTH'(acc_en) == num_q) begin
               state_nxt = DONE;
               load_res  = 1'b1;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      acc_nxt = acc;
      if (clr)
         acc_nxt = '0;
      else if (acc_en)
         acc_nxt = acc_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base_q    <= '0;
         num_q     <= '0;
         issue_cnt <= '0;
         rcv_cnt   <= '0;
         acc       <= '0;
         result_q  <= '0;
         ivalid_q  <= 1'b0;
         lat_q     <= '0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         ivalid_q <= rd_en;
         lat_q    <= (lat_q << 1) | DOT_LAT'(ivalid_q);
         if (load_res)
            result_q <= acc_nxt;
         if (clr) begin
            base_q    <= bus.base_addr;
            num_q     <= bus.num_chunks;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
         end else begin
            if (rd_en)
               issue_cnt <= issue_cnt + 1'b1;
            if (acc_en)
               rcv_cnt <= rcv_cnt + 1'b1;
         end
         // The dot8 instance must return each chunk exactly DOT_LAT cycles after ivalid.
         assert (bus.dot_ovalid == lat_q[DOT_LAT-1]);
      end
   end

   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.result     = result_q;
   assign bus.rd_en      = rd_en;
   // Address arithmetic wraps naturally at AWIDTH bits.
   assign bus.rd_addr    = rd_en ? base_q + AWIDTH'(issue_cnt) : '0;
   assign bus.dot_vec0   = bus.rd_data0;
   assign bus.dot_vec1   = bus.rd_data1;
   assign bus.dot_ivalid = ivalid_q;

endmodule

// File: tb/tb_dot8_seq_ctrl.sv
// Directed bench for dot8_seq_ctrl with a behavioural operand memory and dot8 pipeline.
// Cycle 0 of each job is the cycle in which start is driven high.
module tb_dot8_seq_ctrl;
   localparam int IW = 8;
   localparam int OW = 20;
   localparam int AW = 10;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dot8_seq_ctrl_if #(.IWIDTH(IW), .OWIDTH(OW), .AWIDTH(AW), .CWIDTH(CW)) bus ();

   dot8_seq_ctrl #(.IWIDTH(IW), .OWIDTH(OW), .AWIDTH(AW), .CWIDTH(CW), .DOT_LAT(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Operand memory, 1-cycle read latency.
   logic [8*IW-1:0] mem0 [0:(1<<AW)-1];
   logic [8*IW-1:0] mem1 [0:(1<<AW)-1];
   logic [8*IW-1:0] rdd0 = '0;
   logic [8*IW-1:0] rdd1 = '0;
   always @(posedge clk) begin
      if (bus.rd_en) begin
         rdd0 <= mem0[bus.rd_addr];
         rdd1 <= mem1[bus.rd_addr];
      end
   end
   assign bus.rd_data0 = rdd0;
   assign bus.rd_data1 = rdd1;

   // dot8 model: 5-cycle pipeline, cleared by the shared reset.
   function automatic logic [OW-1:0] dot8(input logic [8*IW-1:0] a, input logic [8*IW-1:0] b);
      int s = 0;
      for (int i = 0; i < 8; i++)
         s += int'($signed(a[i*IW +: IW])) * int'($signed(b[i*IW +: IW]));
      return OW'(s);
   endfunction

   logic [OW-1:0] pd [5];
   logic [4:0]    pv = '0;
   always @(posedge clk) begin
      if (rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[3:0], bus.dot_ivalid};
         pd[0] <= dot8(bus.dot_vec0, bus.dot_vec1);
         for (int k = 1; k < 5; k++)
            pd[k] <= pd[k-1];
      end
   end
   assign bus.dot_result = pd[4];
   assign bus.dot_ovalid = pv[4];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one job for 30 cycles. again_cyc re-pulses start (with other operands);
   // rst_cyc pulses reset for one cycle. Negative values disable either.
   task automatic run_job(input string tag, input logic [AW-1:0] base, input logic [CW-1:0] n,
                          input int again_cyc, input int rst_cyc,
                          output int done_cyc, output int done_cnt, output int rd_cnt,
                          output logic signed [OW-1:0] res);
      logic [AW-1:0] ea;
      done_cyc = -1;
      done_cnt = 0;
      rd_cnt   = 0;
      res      = '0;
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.num_chunks = n;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.rd_en) begin
            ea = base + AW'(rd_cnt);
            check({tag, ".rd_cycle"}, c, rd_cnt + 1);
            check({tag, ".rd_addr"}, bus.rd_addr, ea);
            rd_cnt++;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               res      = bus.result;
            end
         end
         if (rst_cyc >= 0 && c == rst_cyc + 1) begin
            check({tag, ".busy_after_rst"}, bus.busy, 0);
            check({tag, ".result_after_rst"}, bus.result, 0);
         end
         @(posedge clk); #1;
         bus.start = (c + 1 == again_cyc);
         if (c + 1 == again_cyc) begin
            bus.base_addr  = '0;
            bus.num_chunks = 8'd1;
         end else begin
            bus.base_addr  = '1;
            bus.num_chunks = '1;
         end
         rst = (c + 1 == rst_cyc);
      end
      bus.start = 1'b0;
   endtask

   int dc, dn, rc;
   logic signed [OW-1:0] r;

   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         mem0[a] = '0;
         mem1[a] = '0;
      end
      mem0[0]    = {8{8'sd1}};
      mem1[0]    = {8{8'sd1}};
      for (int a = 5; a <= 8; a++) begin
         mem0[a] = {8{8'hFD}};
         mem1[a] = {8{8'h02}};
      end
      for (int a = 100; a <= 104; a++) begin
         mem0[a] = {8{8'h7F}};
         mem1[a] = {8{8'h7F}};
      end
      mem0[1023] = {8{8'd2}};
      mem1[1023] = {8{8'd3}};

      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.num_chunks = '0;
      rst            = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.busy", bus.busy, 0);
      check("reset.done", bus.done, 0);
      check("reset.rd_en", bus.rd_en, 0);
      check("reset.dot_ivalid", bus.dot_ivalid, 0);
      check("reset.result", bus.result, 0);
      check("reset.rd_addr", bus.rd_addr, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // N=1, all-ones lanes
      run_job("t1", 10'd0, 8'd1, -1, -1, dc, dn, rc, r);
      check("t1.done_cycle", dc, 8);
      check("t1.done_count", dn, 1);
      check("t1.reads", rc, 1);
      check("t1.result", r, 8);

      // N=4, (-3)*(+2) lanes
      run_job("t2", 10'd5, 8'd4, -1, -1, dc, dn, rc, r);
      check("t2.done_cycle", dc, 11);
      check("t2.done_count", dn, 1);
      check("t2.reads", rc, 4);
      check("t2.result", r, -192);

      // N=0 finishes immediately
      run_job("t3", 10'd0, 8'd0, -1, -1, dc, dn, rc, r);
      check("t3.done_cycle", dc, 1);
      check("t3.done_count", dn, 1);
      check("t3.reads", rc, 0);
      check("t3.result", r, 0);

      // start re-pulsed mid-job is ignored
      run_job("t4", 10'd5, 8'd4, 3, -1, dc, dn, rc, r);
      check("t4.done_cycle", dc, 11);
      check("t4.done_count", dn, 1);
      check("t4.reads", rc, 4);
      check("t4.result", r, -192);

      // reset mid-job, then a clean N=1 job
      run_job("t5", 10'd5, 8'd4, -1, 5, dc, dn, rc, r);
      check("t5.done_count", dn, 0);
      check("t5.reads", rc, 4);
      run_job("t5b", 10'd0, 8'd1, -1, -1, dc, dn, rc, r);
      check("t5b.done_cycle", dc, 8);
      check("t5b.result", r, 8);

      // 5 x 129032 overflows a 20-bit accumulator
      run_job("t6", 10'd100, 8'd5, -1, -1, dc, dn, rc, r);
      check("t6.done_cycle", dc, 12);
`ifdef DOT8_SEQ_SAT_EN
      check("t6.result", r, 524287);
`else
      check("t6.result", r, -403416);
`endif

      // address wrap: 1023 then 0 -> 48 + 8
      run_job("t7", 10'd1023, 8'd2, -1, -1, dc, dn, rc, r);
      check("t7.done_cycle", dc, 9);
      check("t7.reads", rc, 2);
      check("t7.result", r, 56);

      // start in the done cycle is ignored
      run_job("t8", 10'd0, 8'd1, 8, -1, dc, dn, rc, r);
      check("t8.done_cycle", dc, 8);
      check("t8.done_count", dn, 1);
      check("t8.result", r, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
